// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 / stride-2 pooling stage.
//
// Holds the default image geometry, the pooling mode encodings and the
// combine2() helper. Both the horizontal (pixel pair) and the vertical
// (row pair) stages of pool2x2_stream use combine2().
//
// combine2() works on CW-bit operands. Callers extend their samples to CW
// bits first, using sign or zero extension to match the signedness in use.
// Max mode then needs only a compare and a select. Sum mode is a plain CW-bit
// add, and the caller keeps only the bits it needs.
package pool_pkg;

   localparam int DEF_W  = 64;
   localparam int DEF_H  = 64;
   localparam int DEF_DW = 20;
   localparam int DEF_CH = 2;

   // Working width of combine2(); any storage width up to this fits.
   localparam int CW = 64;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_e;

   // Max of the two operands (signed or unsigned compare), or their sum.
   function automatic logic [CW-1:0] combine2(input logic [CW-1:0] a,
                                               input logic [CW-1:0] b,
                                               input pool_mode_e    mode,
                                               input logic          signed_en);
      logic          a_gt;
      logic [CW-1:0] r;
      if (signed_en) a_gt = ($signed(a) > $signed(b));
      else           a_gt = (a > b);
      r = a_gt ? a : b;
      if (mode == POOL_AVG) r = a + b;
      return r;
   endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Line buffer for pool2x2_stream: synchronous RAM with one write port and
// one read port.
//
// Ports:
//   clk      clock
//   wr_en    write strobe; mem[wr_addr] <= wr_data
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe; rd_data <= mem[rd_addr] on the next edge
//   rd_addr  read address
//   rd_data  registered read data; holds its value while rd_en is low
//
// The contents and the read register are not reset. The owner writes every
// entry before it reads it. When a read and a write hit the same address in
// one cycle, the read returns the old contents.
module pool_linebuf #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 20,
   parameter int ABITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [ABITS-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [ABITS-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write and registered read. Nonblocking assignment gives read-first
   // behaviour when both ports hit the same address.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 pooling stage.
//
// Input is a raster-scan feature map. Channels are interleaved, with the
// channel index changing fastest. Output is the pooled map in raster order,
// with a layer-memory write address and a channel tag on each beat.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready = ~out_valid | out_ready
//   in_data, in_last      sample, and the end-of-frame marker
//   mode                  0 = max, 1 = rounded average (with POOL_AVG_EN)
//   out_valid/out_ready   output handshake
//   out_data/addr/ch      pooled sample, pooled pixel index, channel
//   out_last              final pooled beat of the frame
//   frame_done            pulse on the cycle after the out_last handshake
//   err                   sticky flag: in_last did not match the final beat
//
// Build option POOL_AVG_EN: enables average mode. hreg and the line buffer
// then widen to DW+2 bits to hold partial sums. Without it the design is max
// only and mode is ignored.
module pool2x2_stream
   import pool_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int W      = DEF_W,
   parameter int H      = DEF_H,
   parameter int CH     = DEF_CH,
   parameter int SIGNED = 0,
   parameter int AW     = 12
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DW-1:0]                       in_data,
   input  logic                                in_last,
   input  logic                                mode,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [DW-1:0]                       out_data,
   output logic [AW-1:0]                       out_addr,
   output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch,
   output logic                                out_last,
   output logic                                frame_done,
   output logic                                err
);

`ifdef POOL_AVG_EN
   localparam int SW = DW + 2;
`else
   localparam int SW = DW;
`endif
   localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
   localparam int COLW = $clog2(W);
   localparam int ROWW = $clog2(H);
   localparam int PW   = W / 2;
   localparam int LBD  = PW * CH;
   localparam int LBAW = (LBD > 1) ? $clog2(LBD) : 1;
   localparam logic [CHW-1:0]  CH_MAX  = CHW'(CH - 1);
   localparam logic [COLW-1:0] COL_MAX = COLW'(W - 1);
   localparam logic [ROWW-1:0] ROW_MAX = ROWW'(H - 1);

   logic [CHW-1:0]  ch_cnt,  ch_nxt;
   logic [COLW-1:0] col_cnt, col_nxt;
   logic [ROWW-1:0] row_cnt, row_nxt;
   logic            accept, final_beat, at_origin, load_out;
   logic [SW-1:0]   hreg [CH];
   logic [SW-1:0]   lb_rd_data;
   logic [CW-1:0]   in_cw, h_cw, v_cw;
   logic [DW-1:0]   result;
   logic            unused_bits;
   pool_mode_e      mode_eff;

   // Line buffer slot for a (col, channel) position.
   function automatic logic [LBAW-1:0] lb_index(input logic [COLW-1:0] col,
                                                input logic [CHW-1:0]  ch);
      logic [31:0] v;
      v = 32'(col >> 1) * 32'(CH) + 32'(ch);
      return LBAW'(v);
   endfunction

   // Extends a stored value to the combine2() working width.
   function automatic logic [CW-1:0] to_cw(input logic [SW-1:0] v);
      if (SIGNED != 0) return CW'($signed(v));
      return CW'(v);
   endfunction

   assign in_ready   = ~out_valid | out_ready;
   assign accept     = in_valid & in_ready;
   assign at_origin  = (ch_cnt == '0) && (col_cnt == '0) && (row_cnt == '0);
   assign final_beat = (ch_cnt == CH_MAX) && (col_cnt == COL_MAX) && (row_cnt == ROW_MAX);
   assign load_out   = accept & row_cnt[0] & col_cnt[0];

   // Position of the beat after this one. Channel changes fastest, then
   // column, then row, and everything wraps after the last beat of a frame.
   // in_last is deliberately not used here.
   always_comb begin
      ch_nxt  = ch_cnt + CHW'(1);
      col_nxt = col_cnt;
      row_nxt = row_cnt;
      if (ch_cnt == CH_MAX) begin
         ch_nxt  = '0;
         col_nxt = col_cnt + COLW'(1);
         if (col_cnt == COL_MAX) begin
            col_nxt = '0;
            row_nxt = (row_cnt == ROW_MAX) ? '0 : row_cnt + ROWW'(1);
         end
      end
   end

   // The position counters move only on accepted beats.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ch_cnt  <= '0;
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (accept) begin
         ch_cnt  <= ch_nxt;
         col_cnt <= col_nxt;
         row_cnt <= row_nxt;
      end
   end

`ifdef POOL_AVG_EN
   // Mode is captured on the first beat of a frame and held for the rest of
   // it, so a mid-frame toggle cannot mix max and average results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) mode_eff <= POOL_MAX;
      else if (accept && at_origin) mode_eff <= pool_mode_e'(mode);
   end
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign mode_eff    = POOL_MAX;
`endif

   // Horizontal then vertical combine. h_cw merges the held even-column
   // sample with the current odd-column one. v_cw merges that result with the
   // row above, taken from the line buffer. An average is the 4-sample sum
   // with a rounding +2, keeping bits [DW+1:2].
   always_comb begin
      if (SIGNED != 0) in_cw = CW'($signed(in_data));
      else             in_cw = CW'(in_data);
      h_cw   = combine2(to_cw(hreg[ch_cnt]), in_cw, mode_eff, SIGNED != 0);
      v_cw   = combine2(h_cw, to_cw(lb_rd_data), mode_eff, SIGNED != 0);
      result = v_cw[DW-1:0];
`ifdef POOL_AVG_EN
      begin
         logic [CW-1:0] rnd;
         rnd = v_cw + CW'(2);
         if (mode_eff == POOL_AVG) result = rnd[DW+1:2];
         unused_bits = ^{rnd[CW-1:DW+2], rnd[1:0]};
      end
`else
      unused_bits = ^v_cw[CW-1:DW];
`endif
   end

   // Even-column samples wait here, one per channel, for their odd partner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CH; i++) hreg[i] <= '0;
      end else if (accept && !col_cnt[0]) begin
         hreg[ch_cnt] <= in_cw[SW-1:0];
      end
   end

   // Even rows store their horizontal results. Reads are prefetched for the
   // next beat's slot on every accepted beat, so the data for an odd-row,
   // odd-column beat is already waiting when that beat arrives. The only
   // same-slot read/write overlap falls on an even-column beat, which does
   // not use the data, and the next prefetch re-reads the fresh value.
   pool_linebuf #(
      .DEPTH(LBD),
      .WIDTH(SW),
      .ABITS(LBAW)
   ) u_linebuf (
      .clk    (clk),
      .wr_en  (accept & ~row_cnt[0] & col_cnt[0]),
      .wr_addr(lb_index(col_cnt, ch_cnt)),
      .wr_data(h_cw[SW-1:0]),
      .rd_en  (accept),
      .rd_addr(lb_index(col_nxt, ch_nxt)),
      .rd_data(lb_rd_data)
   );

   // Output register. A new result may load in the same cycle the previous
   // one drains. Otherwise the payload holds until out_ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
      end else if (load_out) begin
         out_valid <= 1'b1;
         out_data  <= result;
         out_addr  <= AW'(32'(row_cnt >> 1) * 32'(PW) + 32'(col_cnt >> 1));
         out_ch    <= ch_cnt;
         out_last  <= final_beat;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Frame completion pulse, plus a sticky flag for any beat whose in_last
   // does not match the position count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         frame_done <= out_valid & out_ready & out_last;
         if (accept && (in_last != final_beat)) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Self-checking bench for pool2x2_stream.
//   dut_a: 4x4, CH=1, unsigned. Ramp frames, backpressure, in_last errors,
//          mid-frame reset.
//   dut_b: 2x2, CH=1, signed. A single negative block, in max mode and in
//          average mode (or with mode ignored when average is not built).
//   dut_c: default 64x64, CH=2. Full frame compared against a closed-form
//          expectation.
module tb_pool2x2_stream;

   logic clk = 1'b0;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // ---------------- dut_a : 4x4, CH=1, unsigned ----------------
   logic        a_in_valid, a_in_ready, a_in_last, a_mode;
   logic [19:0] a_in_data, a_out_data;
   logic        a_out_valid, a_out_ready, a_out_last, a_frame_done, a_err;
   logic [1:0]  a_out_addr;
   logic [0:0]  a_out_ch;

   pool2x2_stream #(.DW(20), .W(4), .H(4), .CH(1), .SIGNED(0), .AW(2)) dut_a (
      .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .in_last(a_in_last), .mode(a_mode),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_addr(a_out_addr), .out_ch(a_out_ch), .out_last(a_out_last),
      .frame_done(a_frame_done), .err(a_err));

   logic [19:0] a_q_data[$];
   int          a_q_addr[$];
   bit          a_q_last[$];
   bit          a_last_pending = 1'b0;
   bit          a_bp_en = 1'b0;
   int          a_bp_cnt = 0;

   // out_ready driver: steady high, or toggling every 3 cycles.
   initial begin
      a_out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (a_bp_en) begin
            a_bp_cnt++;
            if (a_bp_cnt % 3 == 0) a_out_ready = ~a_out_ready;
         end else begin
            a_bp_cnt    = 0;
            a_out_ready = 1'b1;
         end
      end
   end

   // Records output handshakes and checks the frame_done timing. Under
   // backpressure it also checks the in_ready rule on every cycle.
   always @(negedge clk) begin
      if (reset) begin
         a_last_pending = 1'b0;
      end else begin
         if (a_last_pending) checkOutput("a_frame_done", a_frame_done, 1);
         else if (a_frame_done) checkOutput("a_frame_done_spurious", a_frame_done, 0);
         a_last_pending = 1'b0;
         if (a_bp_en) checkOutput("a_in_ready_bp", a_in_ready, !(a_out_valid && !a_out_ready));
         if (a_out_valid && a_out_ready) begin
            a_q_data.push_back(a_out_data);
            a_q_addr.push_back(int'(a_out_addr));
            a_q_last.push_back(a_out_last);
            a_last_pending = a_out_last;
         end
      end
   end

   // Sends ramp beats 0..n_beats-1 to dut_a. in_last is raised on beat
   // last_at; pass -1 for no in_last at all.
   task automatic applyStimulus(input int n_beats, input int last_at);
      int i     = 0;
      int guard = 0;
      bit acc;
      while (i < n_beats && guard < 1000) begin
         a_in_valid = 1'b1;
         a_in_data  = 20'(i);
         a_in_last  = (i == last_at);
         @(negedge clk);
         acc = a_in_ready;
         @(posedge clk); #1;
         if (acc) i++;
         guard++;
      end
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      if (i < n_beats) checkOutput("a_feed_timeout", i, n_beats);
   endtask

   task automatic clearQueues();
      a_q_data.delete();
      a_q_addr.delete();
      a_q_last.delete();
   endtask

   // Waits for the four pooled beats of a 4x4 ramp, then checks them.
   task automatic checkRampFrame(input string tag);
      logic [19:0] expd [4];
      int guard = 0;
      expd = '{20'd5, 20'd7, 20'd13, 20'd15};
      while (a_q_data.size() < 4 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      repeat (4) @(posedge clk);
      #1;
      checkOutput({tag, "_count"}, a_q_data.size(), 4);
      for (int k = 0; k < 4 && k < a_q_data.size(); k++) begin
         checkOutput({tag, "_data"}, a_q_data[k], expd[k]);
         checkOutput({tag, "_addr"}, a_q_addr[k], k);
         checkOutput({tag, "_last"}, a_q_last[k], (k == 3));
      end
      clearQueues();
   endtask

   task automatic doReset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   // ---------------- dut_b : 2x2, CH=1, signed ----------------
   logic        b_in_valid, b_in_ready, b_in_last, b_mode;
   logic [19:0] b_in_data, b_out_data;
   logic        b_out_valid, b_out_ready, b_out_last, b_frame_done, b_err;
   logic [0:0]  b_out_addr;
   logic [0:0]  b_out_ch;

   pool2x2_stream #(.DW(20), .W(2), .H(2), .CH(1), .SIGNED(1), .AW(1)) dut_b (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_last(b_in_last), .mode(b_mode),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_addr(b_out_addr), .out_ch(b_out_ch), .out_last(b_out_last),
      .frame_done(b_frame_done), .err(b_err));

   // Sends the raster block {-3, -1 / -7, -2} and checks the single result.
   task automatic runSigned(input logic m, input logic [19:0] expv, input string tag);
      logic [19:0] blk [4];
      int guard = 0;
      blk    = '{20'hFFFFD, 20'hFFFFF, 20'hFFFF9, 20'hFFFFE};
      b_mode = m;
      for (int i = 0; i < 4; i++) begin
         b_in_valid = 1'b1;
         b_in_data  = blk[i];
         b_in_last  = (i == 3);
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
      while (!b_out_valid && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      checkOutput({tag, "_valid"}, b_out_valid, 1);
      checkOutput({tag, "_data"}, b_out_data, expv);
      checkOutput({tag, "_addr"}, b_out_addr, 0);
      checkOutput({tag, "_last"}, b_out_last, 1);
      @(posedge clk); #1;
      checkOutput({tag, "_err"}, b_err, 0);
   endtask

   // ---------------- dut_c : defaults, 64x64, CH=2 ----------------
   logic        c_in_valid, c_in_ready, c_in_last;
   logic [19:0] c_in_data, c_out_data;
   logic        c_out_valid, c_out_ready, c_out_last, c_frame_done, c_err;
   logic [11:0] c_out_addr;
   logic [0:0]  c_out_ch;
   int          c_cnt = 0;

   pool2x2_stream dut_c (
      .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .in_last(c_in_last), .mode(1'b0),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .out_addr(c_out_addr), .out_ch(c_out_ch), .out_last(c_out_last),
      .frame_done(c_frame_done), .err(c_err));

   // ch0 pools col+row*64 to its bottom-right sample. ch1 pools 4095 minus
   // that, so its maximum is 4095 minus the block's top-left value.
   always @(negedge clk) begin
      if (!reset && c_out_valid && c_out_ready) begin
         int pix, chn, pr, pc, e0, e1;
         pix = c_cnt / 2;
         chn = c_cnt % 2;
         pr  = pix / 32;
         pc  = pix % 32;
         e0  = (2 * pr + 1) * 64 + 2 * pc + 1;
         e1  = 4095 - (2 * pr * 64 + 2 * pc);
         checkOutput("c_data", c_out_data, (chn == 1) ? e1 : e0);
         checkOutput("c_addr", c_out_addr, pix);
         checkOutput("c_ch", c_out_ch, chn);
         checkOutput("c_last", c_out_last, (c_cnt == 2047));
         c_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_mode = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_mode = 1'b0;
      b_out_ready = 1'b1;
      c_in_valid = 1'b0; c_in_data = '0; c_in_last = 1'b0;
      c_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset values
      checkOutput("rst_in_ready", a_in_ready, 1);
      checkOutput("rst_out_valid", a_out_valid, 0);
      checkOutput("rst_out_data", a_out_data, 0);
      checkOutput("rst_out_addr", a_out_addr, 0);
      checkOutput("rst_out_ch", a_out_ch, 0);
      checkOutput("rst_out_last", a_out_last, 0);
      checkOutput("rst_frame_done", a_frame_done, 0);
      checkOutput("rst_err", a_err, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] 4x4 ramp, free running");
      applyStimulus(16, 15);
      checkRampFrame("ramp");
      checkOutput("ramp_err", a_err, 0);

      $display("[TB] 4x4 ramp, out_ready toggling every 3 cycles");
      a_bp_en = 1'b1;
      applyStimulus(16, 15);
      checkRampFrame("bp");
      a_bp_en = 1'b0;
      @(posedge clk); #1;
      checkOutput("bp_err", a_err, 0);

      $display("[TB] in_last on beat 5");
      applyStimulus(16, 5);
      checkRampFrame("early_last");
      checkOutput("early_last_err", a_err, 1);
      applyStimulus(16, 15);
      checkRampFrame("sticky");
      checkOutput("err_sticky", a_err, 1);

      doReset();
      checkOutput("err_cleared", a_err, 0);
      $display("[TB] in_last omitted");
      applyStimulus(16, -1);
      checkRampFrame("no_last");
      checkOutput("no_last_err", a_err, 1);

      $display("[TB] reset mid-frame at beat 9");
      doReset();
      applyStimulus(9, -1);
      repeat (2) @(posedge clk);
      #1;
      doReset();
      clearQueues();
      applyStimulus(16, 15);
      checkRampFrame("after_rst");
      checkOutput("after_rst_err", a_err, 0);

      $display("[TB] signed 2x2 block");
      runSigned(1'b0, 20'hFFFFF, "smax");
      @(posedge clk); #1;
`ifdef POOL_AVG_EN
      runSigned(1'b1, 20'hFFFFD, "savg");
`else
      runSigned(1'b1, 20'hFFFFF, "mode_ignored");
`endif

      $display("[TB] 64x64, 2 channels");
      for (int r = 0; r < 64; r++) begin
         for (int c = 0; c < 64; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
               c_in_valid = 1'b1;
               c_in_data  = (ch == 1) ? 20'(4095 - (c + r * 64)) : 20'(c + r * 64);
               c_in_last  = (r == 63 && c == 63 && ch == 1);
               @(posedge clk); #1;
            end
         end
      end
      c_in_valid = 1'b0;
      c_in_last  = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("c_count", c_cnt, 2048);
      checkOutput("c_err", c_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
